ifetch_queue: RTL and testbench

- Instruction-fetch front end between the program counter register and the decode stage.
- Issues one instruction-memory read per PC value and tells the PC register when to advance, via `pc_stall_o` wired to the PC register's active-low `en`.
- Tracks outstanding reads, buffers returned words with their PCs in a small in-order queue, and presents them to decode with valid/ready.
- On `flush_i` (branch/jump redirect), discards all queued and in-flight fetches.

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/ifq_storage.sv | 36 +++
 rtl/ifetch_queue.sv | 83 ++++++++
 tb/tb_ifetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-path width, default queue depth and queue entry type.
package rv_fetch_pkg;
  localparam int XLEN = 32;
  localparam int DEPTH_DEF = 4;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: fetch-queue entry array with independent alloc, fill and head-read ports.
module ifq_storage
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [PW-1:0]   alloc_ptr,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [PW-1:0]   fill_ptr,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  input  logic [PW-1:0]   rd_ptr,
  output fetch_entry_t    head
);
  fetch_entry_t mem [DEPTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) mem[alloc_ptr] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
      if (fill) begin
        mem[fill_ptr].instr  <= fill_data;
        mem[fill_ptr].filled <= 1'b1;
      end
      if (pop) mem[rd_ptr].filled <= 1'b0;
    end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: issues one imem read per PC, stalls the PC register until accepted,
// and returns fetched words to decode in order; flush drops queued and in-flight reads.
module ifetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_stall_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  input  logic            id_ready_i
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_ptr, rd_ptr, fill_ptr;
  logic [CW-1:0] count, pend, discard;
  logic [CW:0]   flush_discard;
  logic          accept, pop, fill, drop;
  fetch_entry_t  head;
  assign imem_req_valid_o = rst && (count < CW'(DEPTH)) && !flush_i;
  assign imem_req_addr_o  = pc_i;
  assign accept           = imem_req_valid_o && imem_req_ready_i;
  assign pc_stall_o       = !accept;
  assign drop             = imem_rsp_valid_i && (discard != '0);
  assign fill             = imem_rsp_valid_i && (discard == '0) && !flush_i;
  assign id_valid_o       = head.filled && (count != '0);
  assign pop              = id_valid_o && id_ready_i && !flush_i;
  assign id_instr_o       = id_valid_o ? head.instr : '0;
  assign id_pc_o          = id_valid_o ? head.pc : '0;
  // a response arriving with the flush is one of the killed reads, so it is not counted twice
  assign flush_discard = {1'b0, discard} + {1'b0, pend} - (CW+1)'(imem_rsp_valid_i);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend     <= '0;
      discard  <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pend     <= '0;
      discard  <= flush_discard[CW-1:0];
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (fill) fill_ptr <= fill_ptr + 1'b1;
      if (drop) discard <= discard - 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      pend  <= pend + CW'(accept) - CW'(fill);
    end
  ifq_storage #(.DEPTH(DEPTH)) u_store (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .alloc     (accept),
    .alloc_ptr (wr_ptr),
    .alloc_pc  (pc_i),
    .fill      (fill),
    .fill_ptr  (fill_ptr),
    .fill_data (imem_rsp_data_i),
    .pop       (pop),
    .rd_ptr    (rd_ptr),
    .head      (head)
  );
  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid_i |-> (discard != '0 || pend != '0));
  a_discard_range: assert property (@(posedge clk) disable iff (!rst)
    flush_i |-> flush_discard <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus randomized traffic checked every cycle
// against a queue-level model of the fetch queue and an in-order memory.
module tb_ifetch_queue;
  localparam int D = 4;
  localparam logic [31:0] K = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_i, imem_req_addr_o, imem_rsp_data_i, id_instr_o, id_pc_o;
  logic pc_stall_o, flush_i, imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i;
  logic id_valid_o, id_ready_i;
  ifetch_queue #(.DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_stall_o(pc_stall_o), .flush_i(flush_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .id_valid_o(id_valid_o), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_ready_i(id_ready_i)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] data; bit filled;} ent_t;
  typedef struct {logic [31:0] data; int due;} rd_t;
  ent_t q[$];
  rd_t  mq[$];
  int discard = 0, cyc = 0, vectors = 0, miscompares = 0;
  int lat_lo = 1, lat_hi = 1;
  bit rnd = 0, rsp_en = 1, f_flush = 0, f_ready = 1, f_idr = 1;
  logic [31:0] mpc = 0, target = 0, first, first_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst = 1'b0;
    q.delete();
    mq.delete();
    discard = 0;
    mpc = start;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // one clock: drive inputs, compare against model, then advance the model
  task automatic cycle();
    int unf;
    bit rsp_v, exp_rv, acc, exp_idv, pop, done;
    logic [31:0] rsp_d;
    @(negedge clk);
    unf = 0;
    foreach (q[i]) if (!q[i].filled) unf++;
    rsp_v = rsp_en && mq.size() > 0 && mq[0].due <= cyc && (!rnd || $urandom_range(99) < 70);
    rsp_d = rsp_v ? mq[0].data : $urandom;
    if (rsp_v) void'(mq.pop_front());
    if (rnd) begin
      f_flush = ($urandom_range(99) < 4) && (discard + unf - int'(rsp_v) <= D);
      f_ready = $urandom_range(99) < 80;
      f_idr   = $urandom_range(99) < 70;
      target  = $urandom & 32'hFFFF_FFFC;
    end
    pc_i = mpc; flush_i = f_flush; imem_req_ready_i = f_ready; id_ready_i = f_idr;
    imem_rsp_valid_i = rsp_v; imem_rsp_data_i = rsp_d;
    #1;
    exp_rv  = q.size() < D && !f_flush;
    acc     = exp_rv && f_ready;
    exp_idv = q.size() > 0 && q[0].filled;
    pop     = exp_idv && f_idr && !f_flush;
    check("req_valid", imem_req_valid_o, 32'(exp_rv));
    check("pc_stall", pc_stall_o, 32'(!acc));
    check("req_addr", imem_req_addr_o, mpc);
    check("id_valid", id_valid_o, 32'(exp_idv));
    check("id_pc", id_pc_o, exp_idv ? q[0].pc : 32'h0);
    check("id_instr", id_instr_o, exp_idv ? q[0].data : 32'h0);
    if (f_flush) begin
      discard = discard + unf - int'(rsp_v);
      q.delete();
      mpc = target;
    end else begin
      if (rsp_v && discard > 0) discard--;
      else if (rsp_v) begin
        done = 0;
        for (int i = 0; i < q.size(); i++)
          if (!done && !q[i].filled) begin
            q[i].filled = 1;
            q[i].data = rsp_d;
            done = 1;
          end
      end
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back('{pc: mpc, data: 32'h0, filled: 1'b0});
        mq.push_back('{data: rnd ? $urandom : (mpc ^ K), due: cyc + $urandom_range(lat_hi, lat_lo)});
        mpc += 4;
      end
    end
    cyc++;
  endtask

  initial begin
    pc_i = 0; flush_i = 0; imem_req_ready_i = 1; imem_rsp_valid_i = 0;
    imem_rsp_data_i = 0; id_ready_i = 1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_stall", pc_stall_o, 1);
      check("rst_id_valid", id_valid_o, 0);
      check("rst_req_valid", imem_req_valid_o, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i < 2) check("startup_idle", id_valid_o, 0);
      else begin
        check("stream_pc", id_pc_o, 32'(i - 2) * 4);
        check("stream_instr", id_instr_o, (32'(i - 2) * 4) ^ K);
      end
    end
    do_reset(0);
    f_idr = 0;
    repeat (4) cycle();
    repeat (2) begin
      cycle();
      check("full_req_valid", imem_req_valid_o, 0);
      check("full_stall", pc_stall_o, 1);
      check("full_addr", imem_req_addr_o, 32'h10);
    end
    f_idr = 1;
    cycle();
    check("pop_head_pc", id_pc_o, 32'h0);
    check("pop_cycle_req_valid", imem_req_valid_o, 0);
    f_idr = 0;
    cycle();
    check("after_pop_stall", pc_stall_o, 0);
    check("after_pop_addr", imem_req_addr_o, 32'h10);
    f_ready = 0;
    f_idr = 1;
    repeat (5) begin
      cycle();
      check("memstall_stall", pc_stall_o, 1);
      check("memstall_addr", imem_req_addr_o, 32'h14);
    end
    check("memstall_drained", id_valid_o, 0);
    do_reset(32'h20);
    f_ready = 1; f_idr = 0; lat_lo = 3; lat_hi = 3;
    repeat (3) cycle();
    f_ready = 0;
    cycle();
    rsp_en = 0; f_flush = 1; target = 32'h100;
    cycle();
    check("flush_req_valid", imem_req_valid_o, 0);
    rsp_en = 1; f_flush = 0; f_ready = 1; f_idr = 1;
    cycle();
    check("post_flush_valid", id_valid_o, 0);
    first = 0; first_instr = 0;
    for (int i = 0; i < 12 && first == 0; i++) begin
      cycle();
      if (id_valid_o) begin
        first = id_pc_o;
        first_instr = id_instr_o;
      end
    end
    check("redirect_first_pc", first, 32'h100);
    check("redirect_first_instr", first_instr, 32'h100 ^ K);
    do_reset(32'h40);
    lat_lo = 1; lat_hi = 1; f_idr = 0; f_ready = 1;
    repeat (2) cycle();
    f_flush = 1; f_idr = 1; target = 32'h200;
    cycle();
    check("frp_req_valid", imem_req_valid_o, 0);
    check("frp_head_pc", id_pc_o, 32'h40);
    f_flush = 0;
    cycle();
    check("frp_no_spurious", id_valid_o, 0);
    cycle();
    check("frp_fill_latency", id_valid_o, 0);
    cycle();
    check("frp_redirect_pc", id_pc_o, 32'h200);
    do_reset(0);
    f_idr = 0; f_ready = 1;
    repeat (3) cycle();
    check("pre_reset_valid", id_valid_o, 1);
    #1 rst = 1'b0;
    #1;
    check("async_req_valid", imem_req_valid_o, 0);
    check("async_stall", pc_stall_o, 1);
    check("async_id_valid", id_valid_o, 0);
    check("async_id_pc", id_pc_o, 0);
    check("async_id_instr", id_instr_o, 0);
    do_reset(0);
    rnd = 1; lat_lo = 1; lat_hi = 4;
    repeat (3000) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
